// File: rtl/sr_latch_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sr_latch_arbiter
//  Brief    : Round-robin arbiter that lets two requesters write one of four
//             gated SR latches (setup / enable pulse / hold / readback check).
//  Revision : 1.0 - initial release
// ============================================================================
module sr_latch_arbiter #(
  parameter int PULSE_CYC = 2,  // enable pulse width in clk cycles (1..15)
  parameter int NLATCH    = 4   // number of latches, addressed with 2 bits
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              op0,
  input  logic              op1,
  input  logic [1:0]        addr0,
  input  logic [1:0]        addr1,
  input  logic [NLATCH-1:0] q_in,
  output logic [NLATCH-1:0] latch_s,
  output logic [NLATCH-1:0] latch_r,
  output logic [NLATCH-1:0] latch_en,
  output logic              ack0,
  output logic              ack1,
  output logic              err,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_CHECK = 3'd4
  } state_t;

  // Counter reload: the PULSE state is left when the counter reaches zero.
  localparam logic [3:0] c_PULSE_LOAD = 4'(PULSE_CYC - 1);

  state_t            r_state;
  logic              r_op;
  logic [1:0]        r_addr;
  logic              r_id;
  logic              r_last;     // last granted requester, 1 after reset
  logic [3:0]        r_cnt;
  logic [NLATCH-1:0] r_s;
  logic [NLATCH-1:0] r_r;
  logic [NLATCH-1:0] r_en;
  logic              r_ack0;
  logic              r_ack1;
  logic              r_err;
  logic              r_busy;

  logic              w_any;
  logic              w_grant1;
  logic              w_op;
  logic [1:0]        w_addr;
  logic [NLATCH-1:0] w_new_sel;
  logic [NLATCH-1:0] w_sel;

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign w_any     = req0 | req1;
  assign w_grant1  = req1 & (~req0 | ~r_last);
  assign w_op      = w_grant1 ? op1 : op0;
  assign w_addr    = w_grant1 ? addr1 : addr0;
  assign w_new_sel = NLATCH'(1) << w_addr;
  assign w_sel     = NLATCH'(1) << r_addr;

  // Single state machine: state, captured transaction and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= 1'b0;
      r_addr  <= 2'd0;
      r_id    <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= 4'd0;
      r_s     <= '0;
      r_r     <= '0;
      r_en    <= '0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      // Completion strobes are single-cycle unless re-armed below.
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_en <= '0;
          if (w_any) begin
            r_state <= S_SETUP;
            r_op    <= w_op;
            r_addr  <= w_addr;
            r_id    <= w_grant1;
            r_last  <= w_grant1;
            r_s     <= w_op ? w_new_sel : '0;
            r_r     <= w_op ? '0 : w_new_sel;
            r_busy  <= 1'b1;
          end else begin
            r_s    <= '0;
            r_r    <= '0;
            r_busy <= 1'b0;
          end
        end
        S_SETUP: begin
          // S/R have been stable for a full cycle; open the latch gate now.
          r_state <= S_PULSE;
          r_en    <= w_sel;
          r_cnt   <= c_PULSE_LOAD;
        end
        S_PULSE: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_HOLD;
            r_en    <= '0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_HOLD: begin
          // Gate is closed; release S/R and report the readback result.
          r_state <= S_CHECK;
          r_s     <= '0;
          r_r     <= '0;
          r_ack0  <= ~r_id;
          r_ack1  <= r_id;
          r_err   <= (q_in[r_addr] != r_op);
        end
        S_CHECK: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_s     <= '0;
          r_r     <= '0;
          r_en    <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign latch_s  = r_s;
  assign latch_r  = r_r;
  assign latch_en = r_en;
  assign ack0     = r_ack0;
  assign ack1     = r_ack1;
  assign err      = r_err;
  assign busy     = r_busy;

endmodule
`default_nettype wire
